// File: rtl/bmp_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// bmp_frame_scheduler_if
// Bundles every handshake/bus signal of the frame scheduler: the two frame
// requesters (slv0/slv1), the pixel processor issue/result path and the
// master-0 result stream.
//
// Modports:
//   slave  - view of the scheduler itself (takes requests, drives processor
//            and master-0 outputs)
//   master - view of the environment around the scheduler (requesters,
//            processor and downstream consumer)
// ---------------------------------------------------------------------------
interface bmp_frame_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int COLOR_W    = 8,
    parameter int LEN_W      = 16
);
    // requester 0
    logic                  slv0_req;
    logic [1:0]            slv0_mode;
    logic [COLOR_W-1:0]    slv0_proc_val;
    logic [LEN_W-1:0]      slv0_len;
    logic                  slv0_data_valid;
    logic [DATA_WIDTH-1:0] slv0_data;
    logic                  slv0_ready;
    logic                  slv0_gnt;
    // requester 1
    logic                  slv1_req;
    logic [1:0]            slv1_mode;
    logic [COLOR_W-1:0]    slv1_proc_val;
    logic [LEN_W-1:0]      slv1_len;
    logic                  slv1_data_valid;
    logic [DATA_WIDTH-1:0] slv1_data;
    logic                  slv1_ready;
    logic                  slv1_gnt;
    // processor issue / result
    logic                  proc_vld;
    logic [DATA_WIDTH-1:0] proc_data;
    logic                  proc_last;
    logic [1:0]            proc_mode;
    logic [COLOR_W-1:0]    proc_val;
    logic                  proc_out_vld;
    logic [DATA_WIDTH-1:0] proc_out_data;
    // master 0 result stream
    logic                  mstr0_ready;
    logic [DATA_WIDTH-1:0] mstr0_data;
    logic [1:0]            mstr0_data_valid;
    logic                  mstr0_cmplt;
    logic                  err;

    modport slave (
        input  slv0_req, slv0_mode, slv0_proc_val, slv0_len, slv0_data_valid, slv0_data,
        output slv0_ready, slv0_gnt,
        input  slv1_req, slv1_mode, slv1_proc_val, slv1_len, slv1_data_valid, slv1_data,
        output slv1_ready, slv1_gnt,
        output proc_vld, proc_data, proc_last, proc_mode, proc_val,
        input  proc_out_vld, proc_out_data,
        input  mstr0_ready,
        output mstr0_data, mstr0_data_valid, mstr0_cmplt, err
    );

    modport master (
        output slv0_req, slv0_mode, slv0_proc_val, slv0_len, slv0_data_valid, slv0_data,
        input  slv0_ready, slv0_gnt,
        output slv1_req, slv1_mode, slv1_proc_val, slv1_len, slv1_data_valid, slv1_data,
        input  slv1_ready, slv1_gnt,
        input  proc_vld, proc_data, proc_last, proc_mode, proc_val,
        output proc_out_vld, proc_out_data,
        output mstr0_ready,
        input  mstr0_data, mstr0_data_valid, mstr0_cmplt, err
    );
endinterface

// File: rtl/bmp_frame_scheduler.sv
// ---------------------------------------------------------------------------
// bmp_frame_scheduler
// Frame-level round-robin scheduler sharing one pixel processor between two
// requesters. One whole frame is granted at a time; the frame's mode and
// proc_val are latched and presented to the processor for the whole frame.
// Words are issued under credit control so the non-stallable processor output
// always has room in the result FIFO. Results are buffered (tagged with the
// frame owner) toward master 0 and a completion pulse marks each frame.
//
// Ports:
//   i_clk   - clock, rising edge
//   i_rst   - asynchronous active-high reset
//   io_bus  - bmp_frame_scheduler_if.slave: requester, processor and master-0
//             signals (see interface file)
// ---------------------------------------------------------------------------
module bmp_frame_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int COLOR_W    = 8,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    bmp_frame_scheduler_if.slave   io_bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SUM_W = CNT_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_CMPLT  = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_owner;       // 0 = slv0, 1 = slv1
    logic                  r_last_gnt;    // owner of the previous frame
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_cnt;
    logic                  r_gnt0;
    logic                  r_gnt1;
    logic                  r_proc_vld;
    logic                  r_proc_last;
    logic [DATA_WIDTH-1:0] r_proc_data;
    logic [1:0]            r_proc_mode;
    logic [COLOR_W-1:0]    r_proc_val;
    logic                  r_cmplt;
    logic                  r_err;
    logic [CNT_W-1:0]      r_outstanding;
    logic [CNT_W-1:0]      r_fifo_count;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [1:0]            r_tag [FIFO_DEPTH];

    logic                  w_pick;
    logic                  w_credit_ok;
    logic                  w_stream;
    logic                  w_slv0_ready;
    logic                  w_slv1_ready;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_acc_data;
    logic                  w_is_last;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_fifo_vld;
    logic                  w_pop;

    // When both request, the one not granted last wins.
    assign w_pick = (io_bus.slv0_req && io_bus.slv1_req) ? ~r_last_gnt : io_bus.slv1_req;

    // A word sitting in r_proc_vld has not yet reached r_outstanding, so it is
    // counted here too; otherwise one extra word could be issued past the limit.
    assign w_credit_ok = (SUM_W'(r_fifo_count) + SUM_W'(r_outstanding) + SUM_W'(r_proc_vld))
                         < SUM_W'(FIFO_DEPTH);

    assign w_stream     = (r_state == ST_STREAM);
    assign w_slv0_ready = w_stream && !r_owner && w_credit_ok;
    assign w_slv1_ready = w_stream &&  r_owner && w_credit_ok;
    assign w_accept     = (w_slv0_ready && io_bus.slv0_data_valid) ||
                          (w_slv1_ready && io_bus.slv1_data_valid);
    assign w_acc_data   = r_owner ? io_bus.slv1_data : io_bus.slv0_data;
    assign w_is_last    = (r_cnt == (r_len - LEN_W'(1)));

    // Results arriving with no credit outstanding are dropped, never stored.
    assign w_push     = io_bus.proc_out_vld && (r_outstanding != {CNT_W{1'b0}});
    assign w_drop     = io_bus.proc_out_vld && (r_outstanding == {CNT_W{1'b0}});
    assign w_fifo_vld = (r_fifo_count != {CNT_W{1'b0}});
    assign w_pop      = w_fifo_vld && io_bus.mstr0_ready;

    assign io_bus.slv0_ready       = w_slv0_ready;
    assign io_bus.slv1_ready       = w_slv1_ready;
    assign io_bus.slv0_gnt         = r_gnt0;
    assign io_bus.slv1_gnt         = r_gnt1;
    assign io_bus.proc_vld         = r_proc_vld;
    assign io_bus.proc_data        = r_proc_data;
    assign io_bus.proc_last        = r_proc_last;
    assign io_bus.proc_mode        = r_proc_mode;
    assign io_bus.proc_val         = r_proc_val;
    assign io_bus.mstr0_data       = w_fifo_vld ? r_mem[r_rd_ptr] : {DATA_WIDTH{1'b0}};
    assign io_bus.mstr0_data_valid = w_fifo_vld ? r_tag[r_rd_ptr] : 2'b00;
    assign io_bus.mstr0_cmplt      = r_cmplt;
    assign io_bus.err              = r_err;

    // Frame FSM with registered grant, processor-issue and completion outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_last_gnt  <= 1'b1;
            r_len       <= {LEN_W{1'b0}};
            r_cnt       <= {LEN_W{1'b0}};
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_proc_vld  <= 1'b0;
            r_proc_last <= 1'b0;
            r_proc_data <= {DATA_WIDTH{1'b0}};
            r_proc_mode <= 2'b00;
            r_proc_val  <= {COLOR_W{1'b0}};
            r_cmplt     <= 1'b0;
        end else begin
            r_proc_vld  <= 1'b0;
            r_proc_last <= 1'b0;
            r_cmplt     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.slv0_req || io_bus.slv1_req) begin
                        r_owner     <= w_pick;
                        r_gnt0      <= ~w_pick;
                        r_gnt1      <= w_pick;
                        r_proc_mode <= w_pick ? io_bus.slv1_mode     : io_bus.slv0_mode;
                        r_proc_val  <= w_pick ? io_bus.slv1_proc_val : io_bus.slv0_proc_val;
                        r_len       <= w_pick ? io_bus.slv1_len      : io_bus.slv0_len;
                        r_cnt       <= {LEN_W{1'b0}};
                        r_state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (r_len == {LEN_W{1'b0}}) begin
                        r_cmplt <= 1'b1;
                        r_state <= ST_CMPLT;
                    end else begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_accept) begin
                        r_proc_vld  <= 1'b1;
                        r_proc_data <= w_acc_data;
                        r_proc_last <= w_is_last;
                        r_cnt       <= r_cnt + LEN_W'(1);
                        if (w_is_last) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The final word may still sit in r_proc_vld before it is counted.
                    if ((r_outstanding == {CNT_W{1'b0}}) && !w_fifo_vld && !r_proc_vld) begin
                        r_cmplt <= 1'b1;
                        r_state <= ST_CMPLT;
                    end
                end
                ST_CMPLT: begin
                    r_gnt0     <= 1'b0;
                    r_gnt1     <= 1'b0;
                    r_last_gnt <= r_owner;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Credit counter, sticky error and FIFO pointer/occupancy bookkeeping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_outstanding <= {CNT_W{1'b0}};
            r_err         <= 1'b0;
            r_wr_ptr      <= {PTR_W{1'b0}};
            r_rd_ptr      <= {PTR_W{1'b0}};
            r_fifo_count  <= {CNT_W{1'b0}};
        end else begin
            case ({r_proc_vld, w_push})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_drop) begin
                r_err <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + CNT_W'(1);
                2'b01:   r_fifo_count <= r_fifo_count - CNT_W'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    // FIFO storage; each entry keeps the tag of the frame that produced it.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= io_bus.proc_out_data;
            r_tag[r_wr_ptr] <= r_owner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: tb/tb_bmp_frame_scheduler.sv
module tb_bmp_frame_scheduler;
    localparam int DW = 32, CW = 8, LW = 16, DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bmp_frame_scheduler_if #(.DATA_WIDTH(DW), .COLOR_W(CW), .LEN_W(LW)) bus ();
    bmp_frame_scheduler #(.DATA_WIDTH(DW), .COLOR_W(CW), .LEN_W(LW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .io_bus(bus.slave));

    typedef struct { logic [31:0] res; int due; } pq_t;

    int n_tests = 0, n_fail = 0;
    pq_t pq[$];
    logic [31:0] wq0[$], wq1[$], fw0[$], fw1[$];
    logic [33:0] exp_q[$], got_q[$];
    int exp_order[$], got_order[$], fend_q[$];
    logic [1:0] p_mode[2];
    logic [7:0] p_val[2];
    int p_len[2];
    int cyc = 0, lat = 3, rmode = 0, vgap = 0, rr_last = 1;
    int cmplt_cnt = 0, issued = 0, frame_issued = 0, frame_len = 0, last_cnt = 0, res_cnt = 0;
    int acc_cnt = 0, delivered = 0, exp_total = 0;
    int last_viol = 0, early_cmplt = 0, hold_viol = 0, mode_viol = 0, own_viol = 0, credit_viol = 0;
    bit spur = 0;
    logic prev_g0 = 0, prev_g1 = 0, prev_hold = 0;
    logic [33:0] prev_beat;
    int base_i, base_l, base_c;

    // Behaviour of the attached processor; the scheduler only forwards it.
    function automatic logic [31:0] proc_fn(logic [31:0] d, logic [1:0] m, logic [7:0] v);
        case (m)
            2'd0:    return d;
            2'd1:    return d ^ {4{v}};
            2'd2:    return d + {24'd0, v};
            default: return ~d;
        endcase
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // One clock of environment activity, performed at the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.slv0_gnt && !prev_g0) begin
            got_order.push_back(0); frame_len = p_len[0]; frame_issued = 0;
            if (bus.proc_mode !== p_mode[0] || bus.proc_val !== p_val[0]) mode_viol++;
        end
        if (bus.slv1_gnt && !prev_g1) begin
            got_order.push_back(1); frame_len = p_len[1]; frame_issued = 0;
            if (bus.proc_mode !== p_mode[1] || bus.proc_val !== p_val[1]) mode_viol++;
        end
        prev_g0 = bus.slv0_gnt; prev_g1 = bus.slv1_gnt;
        if ((bus.slv0_ready && !bus.slv0_gnt) || (bus.slv1_ready && !bus.slv1_gnt)) own_viol++;
        // processor model: in-order, fixed latency per frame
        if (bus.proc_vld) begin
            issued++; frame_issued++;
            pq.push_back('{res: proc_fn(bus.proc_data, bus.proc_mode, bus.proc_val), due: cyc + lat});
            if (bus.proc_last !== (frame_issued == frame_len)) last_viol++;
            if (bus.proc_last) last_cnt++;
        end else if (bus.proc_last) last_viol++;
        if (spur) begin
            bus.proc_out_vld = 1'b1; bus.proc_out_data = $urandom; spur = 0;
        end else if (pq.size() > 0 && pq[0].due <= cyc) begin
            bus.proc_out_vld = 1'b1; bus.proc_out_data = pq[0].res; pq.delete(0); res_cnt++;
        end else begin
            bus.proc_out_vld = 1'b0; bus.proc_out_data = '0;
        end
        if (bus.mstr0_cmplt) begin
            cmplt_cnt++;
            if (fend_q.size() == 0 || delivered < fend_q[0]) early_cmplt++;
            if (fend_q.size() > 0) fend_q.delete(0);
        end
        // requesters: req held until gnt rises, words offered while granted
        if (bus.slv0_gnt) bus.slv0_req = 1'b0;
        if (bus.slv1_gnt) bus.slv1_req = 1'b0;
        bus.slv0_data_valid = bus.slv0_gnt && wq0.size() > 0 && (vgap == 0 || $urandom_range(0, 3) != 0);
        if (wq0.size() > 0) bus.slv0_data = wq0[0];
        bus.slv1_data_valid = bus.slv1_gnt && wq1.size() > 0 && (vgap == 0 || $urandom_range(0, 3) != 0);
        if (wq1.size() > 0) bus.slv1_data = wq1[0];
        if (bus.slv0_data_valid && bus.slv0_ready) begin wq0.delete(0); acc_cnt++; end
        if (bus.slv1_data_valid && bus.slv1_ready) begin wq1.delete(0); acc_cnt++; end
        // downstream consumer
        case (rmode)
            0:       bus.mstr0_ready = 1'b1;
            1:       bus.mstr0_ready = 1'b0;
            default: bus.mstr0_ready = ($urandom_range(0, 1) == 1);
        endcase
        if (prev_hold && {bus.mstr0_data_valid, bus.mstr0_data} !== prev_beat) hold_viol++;
        if (bus.mstr0_data_valid != 2'b00 && bus.mstr0_ready) begin
            got_q.push_back({bus.mstr0_data_valid, bus.mstr0_data}); delivered++;
        end
        prev_hold = (bus.mstr0_data_valid != 2'b00) && !bus.mstr0_ready;
        prev_beat = {bus.mstr0_data_valid, bus.mstr0_data};
        if (issued - delivered > DEPTH) credit_viol++;
    endtask

    task automatic post(int n, int mode, int val, int len);
        logic [31:0] w;
        p_mode[n] = 2'(mode); p_val[n] = 8'(val); p_len[n] = len;
        for (int i = 0; i < len; i++) begin
            w = $urandom;
            if (n == 0) begin wq0.push_back(w); fw0.push_back(w); end
            else        begin wq1.push_back(w); fw1.push_back(w); end
        end
        if (n == 0) begin
            bus.slv0_req = 1'b1; bus.slv0_mode = 2'(mode); bus.slv0_proc_val = 8'(val); bus.slv0_len = 16'(len);
        end else begin
            bus.slv1_req = 1'b1; bus.slv1_mode = 2'(mode); bus.slv1_proc_val = 8'(val); bus.slv1_len = 16'(len);
        end
    endtask

    // Reference model: frames delivered whole, in round-robin grant order.
    task automatic model_frame(int n);
        exp_order.push_back(n);
        if (n == 0) begin
            foreach (fw0[i]) exp_q.push_back({2'b01, proc_fn(fw0[i], p_mode[0], p_val[0])});
            fw0.delete();
        end else begin
            foreach (fw1[i]) exp_q.push_back({2'b10, proc_fn(fw1[i], p_mode[1], p_val[1])});
            fw1.delete();
        end
        exp_total += p_len[n];
        fend_q.push_back(exp_total);
        rr_last = n;
    endtask

    task automatic model_batch(bit p0, bit p1);
        int first;
        if (p0 && p1) begin
            first = (rr_last == 0) ? 1 : 0;
            model_frame(first); model_frame(1 - first);
        end else if (p0) model_frame(0);
        else if (p1) model_frame(1);
    endtask

    task automatic wait_cmplt(string tag, int target, int budget);
        int k = 0;
        while (cmplt_cnt < target && k < budget) begin tick(); k++; end
        check({tag, "_cmplt_count"}, 64'(cmplt_cnt), 64'(target));
        repeat (3) tick();
    endtask

    task automatic compare_all(string tag);
        check({tag, "_beats"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_beat"}, 64'(got_q[i]), 64'(exp_q[i]));
        check({tag, "_ngrants"}, 64'(got_order.size()), 64'(exp_order.size()));
        for (int i = 0; i < exp_order.size() && i < got_order.size(); i++)
            check({tag, "_grant"}, 64'(got_order[i]), 64'(exp_order[i]));
        check({tag, "_protocol"}, {last_viol[15:0], early_cmplt[15:0], hold_viol[15:0], mode_viol[7:0], own_viol[7:0]}, 64'd0);
        check({tag, "_credit"}, 64'(credit_viol), 64'd0);
        got_q.delete(); exp_q.delete(); got_order.delete(); exp_order.delete();
    endtask

    task automatic check_outputs_zero(string tag);
        check({tag, "_ctl"}, {bus.slv0_ready, bus.slv1_ready, bus.slv0_gnt, bus.slv1_gnt, bus.proc_vld,
                              bus.proc_last, bus.proc_mode, bus.proc_val, bus.mstr0_data_valid,
                              bus.mstr0_cmplt, bus.err}, 64'd0);
        check({tag, "_data"}, {bus.proc_data, bus.mstr0_data}, 64'd0);
    endtask

    initial begin
        bus.slv0_req = 0; bus.slv0_mode = 0; bus.slv0_proc_val = 0; bus.slv0_len = 0;
        bus.slv0_data_valid = 0; bus.slv0_data = 0;
        bus.slv1_req = 0; bus.slv1_mode = 0; bus.slv1_proc_val = 0; bus.slv1_len = 0;
        bus.slv1_data_valid = 0; bus.slv1_data = 0;
        bus.proc_out_vld = 0; bus.proc_out_data = 0; bus.mstr0_ready = 1;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) tick();

        // two simultaneous requests, twice in a row
        lat = 2; rmode = 0; vgap = 1;
        post(0, 1, 8'h5a, 3); post(1, 3, 8'h11, 2); model_batch(1, 1);
        wait_cmplt("t2a", cmplt_cnt + 2, 300);
        post(0, 0, 8'h01, 2); post(1, 2, 8'h22, 3); model_batch(1, 1);
        wait_cmplt("t2b", cmplt_cnt + 2, 300);
        compare_all("t2");

        // single 4-word frame, processor latency 3
        lat = 3; rmode = 0; vgap = 0;
        base_i = issued; base_l = last_cnt;
        post(0, 2, 8'h40, 4); model_batch(1, 0);
        wait_cmplt("t1", cmplt_cnt + 1, 200);
        check("t1_mode", 64'(bus.proc_mode), 64'd2);
        check("t1_val", 64'(bus.proc_val), 64'h40);
        check("t1_issued", 64'(issued - base_i), 64'd4);
        check("t1_last", 64'(last_cnt - base_l), 64'd1);
        compare_all("t1");

        // back-pressure: 20 words with master stalled
        lat = 2; rmode = 1; vgap = 0; acc_cnt = 0;
        post(0, 3, 8'h07, 20); model_batch(1, 0);
        repeat (60) tick();
        check("t3_accepted_stalled", 64'(acc_cnt), 64'(DEPTH));
        check("t3_head_tag", 64'(bus.mstr0_data_valid), 64'd1);
        rmode = 2;
        wait_cmplt("t3", cmplt_cnt + 1, 600);
        check("t3_accepted_total", 64'(acc_cnt), 64'd20);
        compare_all("t3");

        // zero-length frame
        base_i = issued; base_c = cmplt_cnt;
        post(1, 1, 8'h33, 0); model_batch(0, 1);
        wait_cmplt("t4", cmplt_cnt + 1, 50);
        check("t4_no_issue", 64'(issued - base_i), 64'd0);
        compare_all("t4");

        // randomized frames
        for (int it = 0; it < 6; it++) begin
            int sel;
            sel = $urandom_range(1, 3);
            lat = $urandom_range(1, 5);
            rmode = ($urandom_range(0, 1) == 1) ? 2 : 0;
            vgap = 1;
            if (sel[0]) post(0, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 12));
            if (sel[1]) post(1, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 12));
            model_batch(sel[0], sel[1]);
            wait_cmplt("rnd", cmplt_cnt + ((sel == 3) ? 2 : 1), 800);
            compare_all("rnd");
        end
        check("err_clean", 64'(bus.err), 64'd0);

        // reset in the middle of a frame with results buffered and in flight
        lat = 4; rmode = 1; vgap = 0; base_c = res_cnt;
        post(0, 1, 8'h99, 12); model_batch(1, 0);
        for (int k = 0; k < 100 && res_cnt - base_c < 3; k++) tick();
        check("t5_buffered", 64'(bus.mstr0_data_valid), 64'd1);
        #2 rst = 1'b1;
        #1 check_outputs_zero("t5_async");
        pq.delete(); wq0.delete(); wq1.delete(); fw0.delete(); fw1.delete();
        exp_q.delete(); got_q.delete(); exp_order.delete(); got_order.delete(); fend_q.delete();
        bus.slv0_req = 0; bus.slv1_req = 0; bus.slv0_data_valid = 0; bus.slv1_data_valid = 0;
        bus.proc_out_vld = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rr_last = 1; delivered = 0; exp_total = 0; issued = 0; prev_hold = 0;
        prev_g0 = 0; prev_g1 = 0;
        lat = 2; rmode = 0;
        post(1, 2, 8'h0f, 5); model_batch(0, 1);
        wait_cmplt("t5", cmplt_cnt + 1, 200);
        compare_all("t5");
        check("t5_err", 64'(bus.err), 64'd0);

        // spurious processor result while idle
        spur = 1;
        repeat (3) tick();
        check("t6_err", 64'(bus.err), 64'd1);
        check("t6_fifo_empty", 64'(bus.mstr0_data_valid), 64'd0);
        repeat (5) tick();
        check("t6_err_sticky", 64'(bus.err), 64'd1);
        check("t6_no_beats", 64'(got_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
